// File: rtl/pie_pkg.sv
// Shared definitions for the Gen2 PIE frame encoder: FSM states and default
// symbol timing in baseband samples.
package pie_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DELIM,
      ST_DATA0,
      ST_RTCAL,
      ST_TRCAL,
      ST_BITS
   } pie_state_t;

   localparam int PIE_PW_SAMPLES    = 2;
   localparam int PIE_DATA0_SAMPLES = 6;
   localparam int PIE_DATA1_SAMPLES = 10;
   localparam int PIE_DELIM_SAMPLES = 3;
   localparam int PIE_TRCAL_SAMPLES = 24;

   // RTcal spans one data-0 plus one data-1 symbol.
   function automatic int rtcal_samples(input int data0, input int data1);
      return data0 + data1;
   endfunction

endpackage

// File: rtl/pie_symbol_timer.sv
// Sample counter for one PIE element: shapes the high/low split and flags the
// last sample of the element so the controller can step.
module pie_symbol_timer
   import pie_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             adv,
   input  logic [CNT_W-1:0] len,
   input  logic [CNT_W-1:0] pw,
   output logic             high,
   output logic             boundary
);

   logic [CNT_W-1:0] cnt;

   assign boundary = adv & (cnt == (len - CNT_W'(1)));
   assign high     = (cnt < (len - pw));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (adv) begin
         cnt <= boundary ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pie_frame_encoder.sv
// Gen2 reader-to-tag PIE frame encoder: delimiter, preamble or frame-sync, then
// start_len data bits pulled from a ready/valid stream, one sample per out_rdy.
module pie_frame_encoder
   import pie_pkg::*;
#(
   parameter int PW_SAMPLES    = PIE_PW_SAMPLES,
   parameter int DATA0_SAMPLES = PIE_DATA0_SAMPLES,
   parameter int DATA1_SAMPLES = PIE_DATA1_SAMPLES,
   parameter int DELIM_SAMPLES = PIE_DELIM_SAMPLES,
   parameter int TRCAL_SAMPLES = PIE_TRCAL_SAMPLES,
   parameter int CNT_W         = 8,
   parameter int LEN_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_rdy,
   input  logic             start_preamble,
   input  logic [LEN_W-1:0] start_len,
   input  logic             in_bit,
   input  logic             in_valid,
   output logic             in_rdy,
   output logic             out_pie,
   input  logic             out_rdy,
   output logic             busy,
   output logic             done,
   output logic             underflow
);

   localparam logic [CNT_W-1:0] LEN_PW    = CNT_W'(PW_SAMPLES);
   localparam logic [CNT_W-1:0] LEN_DELIM = CNT_W'(DELIM_SAMPLES);
   localparam logic [CNT_W-1:0] LEN_DATA0 = CNT_W'(DATA0_SAMPLES);
   localparam logic [CNT_W-1:0] LEN_DATA1 = CNT_W'(DATA1_SAMPLES);
   localparam logic [CNT_W-1:0] LEN_RTCAL = CNT_W'(rtcal_samples(DATA0_SAMPLES, DATA1_SAMPLES));
   localparam logic [CNT_W-1:0] LEN_TRCAL = CNT_W'(TRCAL_SAMPLES);

   pie_state_t       state, state_n;
   logic [LEN_W-1:0] remaining;
   logic             preamble_q;
   logic             cur_bit;
   logic             done_q, underflow_q;

   logic [CNT_W-1:0] sym_len;
   logic             sym_high, sym_boundary;
   logic             start_fire;
   logic             do_load, take_bit, finish_done, finish_uf;

   assign start_rdy  = (state == ST_IDLE);
   assign busy       = (state != ST_IDLE);
   assign done       = done_q;
   assign underflow  = underflow_q;
   assign start_fire = start_valid & start_rdy;

   pie_symbol_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (state == ST_IDLE),
      .adv      (out_rdy),
      .len      (sym_len),
      .pw       (LEN_PW),
      .high     (sym_high),
      .boundary (sym_boundary)
   );

   always_comb begin
      sym_len = LEN_DATA0;
      out_pie = sym_high;
      case (state)
         ST_IDLE: begin
            sym_len = LEN_DATA0;
            out_pie = 1'b1;
         end
         ST_DELIM: begin
            sym_len = LEN_DELIM;
            out_pie = 1'b0;
         end
         ST_DATA0: sym_len = LEN_DATA0;
         ST_RTCAL: sym_len = LEN_RTCAL;
         ST_TRCAL: sym_len = LEN_TRCAL;
         ST_BITS:  sym_len = cur_bit ? LEN_DATA1 : LEN_DATA0;
         default:  sym_len = LEN_DATA0;
      endcase
   end

   always_comb begin
      state_n     = state;
      do_load     = 1'b0;
      in_rdy      = 1'b0;
      take_bit    = 1'b0;
      finish_done = 1'b0;
      finish_uf   = 1'b0;
      case (state)
         ST_IDLE:  if (start_fire) state_n = ST_DELIM;
         ST_DELIM: if (sym_boundary) state_n = ST_DATA0;
         ST_DATA0: if (sym_boundary) state_n = ST_RTCAL;
         ST_RTCAL: begin
            if (sym_boundary) begin
               if (preamble_q) state_n = ST_TRCAL;
               else            do_load = 1'b1;
            end
         end
         ST_TRCAL: if (sym_boundary) do_load = 1'b1;
         ST_BITS:  if (sym_boundary) do_load = 1'b1;
         default:  state_n = ST_IDLE;
      endcase
      // The next bit is fetched exactly on the last sample of the preceding element.
      if (do_load) begin
         if (remaining != '0) begin
            in_rdy = 1'b1;
            if (in_valid) begin
               take_bit = 1'b1;
               state_n  = ST_BITS;
            end else begin
               finish_uf = 1'b1;
               state_n   = ST_IDLE;
            end
         end else begin
            finish_done = 1'b1;
            state_n     = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         remaining   <= '0;
         done_q      <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state       <= state_n;
         done_q      <= finish_done;
         underflow_q <= finish_uf;
         if (start_fire) begin
            remaining <= start_len;
         end else if (take_bit) begin
            remaining <= remaining - LEN_W'(1);
         end
      end
   end

   // Frame parameters and the current bit carry no reset; they are always
   // written before the state that consumes them.
   always_ff @(posedge clk) begin
      if (start_fire) preamble_q <= start_preamble;
      if (take_bit)   cur_bit    <= in_bit;
   end

endmodule
